rf_wb_scheduler: RTL and testbench

Writeback scheduler for the 32×32 integer register file, which has a single write port. It arbitrates round-robin between two writeback requesters: execute (A) and load (B). It drives the register file write port from a one-stage output register. It also keeps a 32-bit pending-write scoreboard so issue logic can stall on operands whose writes have not yet landed.

---
 rtl/rf_pkg.sv | 16 +
 rtl/rr_arb2.sv | 34 +++
 rtl/rf_wb_scheduler.sv | 117 +++++++++++
 tb/tb_rf_wb_scheduler.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rf_pkg.sv
// Shared types and defaults for the register file writeback scheduler.
package rf_pkg;

  localparam int DEFAULT_XLEN = 32;
  localparam int DEFAULT_NREG = 32;
  localparam int REG_ADDR_W   = 5;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

  // Identifies which writeback requester owns the write port.
  typedef enum logic {
    WB_SRC_A = 1'b0,
    WB_SRC_B = 1'b1
  } wb_src_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-request round-robin arbiter. On a tie, the requester that was not
// granted most recently wins. Grants are combinational on the requests.
// The history flop moves only when a grant is actually issued.
module rr_arb2
  import rf_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic req_a,
  input  logic req_b,
  output logic gnt_a,
  output logic gnt_b
);

  wb_src_t last_grant;

  // Grant a lone requester outright; break ties against the last winner.
  always_comb begin
    gnt_a = req_a && (!req_b || (last_grant == WB_SRC_B));
    gnt_b = req_b && (!req_a || (last_grant == WB_SRC_A));
  end

  // Remember the last winner. Reset to B so that A takes the first tie.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant <= WB_SRC_B;
    end else if (gnt_a) begin
      last_grant <= WB_SRC_A;
    end else if (gnt_b) begin
      last_grant <= WB_SRC_B;
    end
  end

endmodule

// File: rtl/rf_wb_scheduler.sv
// Writeback scheduler for the single-write-port integer register file.
// It arbitrates execute (A) and load (B) writebacks into a registered write
// port, and keeps a pending-write scoreboard for issue stalls.
// Optional feature: define RF_WB_FWD_EN to add write-port forwarding outputs
// that mask busy for operands being written this cycle.
module rf_wb_scheduler
  import rf_pkg::*;
#(
  parameter int XLEN = DEFAULT_XLEN,
  parameter int NREG = DEFAULT_NREG
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            iss_valid,
  input  reg_addr_t       iss_rd,
  input  logic            a_valid,
  input  reg_addr_t       a_rd,
  input  logic [XLEN-1:0] a_data,
  output logic            a_ready,
  input  logic            b_valid,
  input  reg_addr_t       b_rd,
  input  logic [XLEN-1:0] b_data,
  output logic            b_ready,
  output logic            rf_we,
  output reg_addr_t       rf_rd_addr,
  output logic [XLEN-1:0] rf_wdata,
  input  reg_addr_t       q_rs1,
  input  reg_addr_t       q_rs2,
  output logic            rs1_busy,
  output logic            rs2_busy,
  output logic [NREG-1:0] pending
`ifdef RF_WB_FWD_EN
  ,
  output logic            rs1_fwd,
  output logic            rs2_fwd,
  output logic [XLEN-1:0] fwd_data
`endif
);

  logic            gnt_a;
  logic            gnt_b;
  logic [NREG-1:0] pending_next;

  rr_arb2 u_arb (
    .clk   (clk),
    .rst   (rst),
    .req_a (a_valid),
    .req_b (b_valid),
    .gnt_a (gnt_a),
    .gnt_b (gnt_b)
  );

  assign a_ready = gnt_a;
  assign b_ready = gnt_b;

  // Output stage: capture the granted request. Writes to x0 are consumed
  // without raising the write enable. Address and data hold when idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rf_we      <= 1'b0;
      rf_rd_addr <= '0;
      rf_wdata   <= '0;
    end else if (gnt_a) begin
      rf_we      <= (a_rd != '0);
      rf_rd_addr <= a_rd;
      rf_wdata   <= a_data;
    end else if (gnt_b) begin
      rf_we      <= (b_rd != '0);
      rf_rd_addr <= b_rd;
      rf_wdata   <= b_data;
    end else begin
      rf_we      <= 1'b0;
    end
  end

  // Scoreboard next state: clear the landing write first, so that a
  // same-cycle issue to the same register leaves the bit set. x0 never
  // becomes pending.
  always_comb begin
    pending_next = pending;
    if (rf_we) begin
      pending_next[rf_rd_addr] = 1'b0;
    end
    if (iss_valid) begin
      pending_next[iss_rd] = 1'b1;
    end
    pending_next[0] = 1'b0;
  end

  // Scoreboard register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending <= '0;
    end else begin
      pending <= pending_next;
    end
  end

`ifdef RF_WB_FWD_EN
  // Forward the value on the write port to a matching nonzero query, and
  // hide its busy bit so the dependent instruction can issue a cycle early.
  always_comb begin
    rs1_fwd  = rf_we && (rf_rd_addr == q_rs1) && (q_rs1 != '0);
    rs2_fwd  = rf_we && (rf_rd_addr == q_rs2) && (q_rs2 != '0);
    fwd_data = rf_wdata;
    rs1_busy = pending[q_rs1] && !rs1_fwd;
    rs2_busy = pending[q_rs2] && !rs2_fwd;
  end
`else
  // Busy is the scoreboard bit of the queried register.
  always_comb begin
    rs1_busy = pending[q_rs1];
    rs2_busy = pending[q_rs2];
  end
`endif

endmodule

// File: tb/tb_rf_wb_scheduler.sv
// Directed testbench for rf_wb_scheduler. Each scenario task drives inputs and
// checks its results against hand-computed expected values.
module tb_rf_wb_scheduler;

  logic        clk;
  logic        rst;
  logic        iss_valid;
  logic [4:0]  iss_rd;
  logic        a_valid;
  logic [4:0]  a_rd;
  logic [31:0] a_data;
  logic        a_ready;
  logic        b_valid;
  logic [4:0]  b_rd;
  logic [31:0] b_data;
  logic        b_ready;
  logic        rf_we;
  logic [4:0]  rf_rd_addr;
  logic [31:0] rf_wdata;
  logic [4:0]  q_rs1;
  logic [4:0]  q_rs2;
  logic        rs1_busy;
  logic        rs2_busy;
  logic [31:0] pending;
`ifdef RF_WB_FWD_EN
  logic        rs1_fwd;
  logic        rs2_fwd;
  logic [31:0] fwd_data;
`endif

  int total;
  int bad;

  rf_wb_scheduler dut (
    .clk        (clk),
    .rst        (rst),
    .iss_valid  (iss_valid),
    .iss_rd     (iss_rd),
    .a_valid    (a_valid),
    .a_rd       (a_rd),
    .a_data     (a_data),
    .a_ready    (a_ready),
    .b_valid    (b_valid),
    .b_rd       (b_rd),
    .b_data     (b_data),
    .b_ready    (b_ready),
    .rf_we      (rf_we),
    .rf_rd_addr (rf_rd_addr),
    .rf_wdata   (rf_wdata),
    .q_rs1      (q_rs1),
    .q_rs2      (q_rs2),
    .rs1_busy   (rs1_busy),
    .rs2_busy   (rs2_busy),
    .pending    (pending)
`ifdef RF_WB_FWD_EN
    ,
    .rs1_fwd    (rs1_fwd),
    .rs2_fwd    (rs2_fwd),
    .fwd_data   (fwd_data)
`endif
  );

  // Free-running clock, 10 time units per period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    iss_valid = 1'b0; iss_rd = '0;
    a_valid = 1'b0; a_rd = '0; a_data = '0;
    b_valid = 1'b0; b_rd = '0; b_data = '0;
    q_rs1 = '0; q_rs2 = '0;
    #12;
    total++;
    if (rf_we !== 1'b0) begin
      bad++; $display("[TB] FAIL reset_rf_we got=%b exp=0", rf_we);
    end
    total++;
    if (pending !== 32'h0) begin
      bad++; $display("[TB] FAIL reset_pending got=%h exp=00000000", pending);
    end
    total++;
    if (rf_wdata !== 32'h0 || rf_rd_addr !== 5'd0) begin
      bad++; $display("[TB] FAIL reset_outreg got=%0d/%h exp=0/00000000", rf_rd_addr, rf_wdata);
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_contention();
    logic [31:0] exp_data;
    a_valid = 1'b1; a_rd = 5'd1; a_data = 32'h1111_1111;
    b_valid = 1'b1; b_rd = 5'd2; b_data = 32'h2222_2222;
    for (int i = 0; i < 4; i++) begin
      #1;
      total++;
      if (a_ready !== ((i % 2) == 0) || b_ready !== ((i % 2) == 1)) begin
        bad++; $display("[TB] FAIL tie_grant%0d got=a%b/b%b exp=a%b", i, a_ready, b_ready, ((i % 2) == 0));
      end
      step();
      exp_data = ((i % 2) == 0) ? 32'h1111_1111 : 32'h2222_2222;
      total++;
      if (rf_we !== 1'b1 || rf_wdata !== exp_data) begin
        bad++; $display("[TB] FAIL tie_write%0d got=%b/%h exp=1/%h", i, rf_we, rf_wdata, exp_data);
      end
    end
    a_valid = 1'b0; b_valid = 1'b0;
    step();
  endtask

  task automatic test_single_a();
    a_valid = 1'b1; a_rd = 5'd5; a_data = 32'hDEAD_BEEF;
    #1;
    total++;
    if (a_ready !== 1'b1 || b_ready !== 1'b0) begin
      bad++; $display("[TB] FAIL single_ready got=a%b/b%b exp=a1/b0", a_ready, b_ready);
    end
    step();
    a_valid = 1'b0;
    total++;
    if (rf_we !== 1'b1 || rf_rd_addr !== 5'd5 || rf_wdata !== 32'hDEAD_BEEF) begin
      bad++; $display("[TB] FAIL single_write got=%b/%0d/%h exp=1/5/deadbeef", rf_we, rf_rd_addr, rf_wdata);
    end
    step();
    total++;
    if (rf_we !== 1'b0 || rf_wdata !== 32'hDEAD_BEEF) begin
      bad++; $display("[TB] FAIL single_idle got=%b/%h exp=0/deadbeef", rf_we, rf_wdata);
    end
  endtask

  task automatic test_x0();
    b_valid = 1'b1; b_rd = 5'd0; b_data = 32'h0000_0055;
    #1;
    total++;
    if (b_ready !== 1'b1) begin
      bad++; $display("[TB] FAIL x0_ready got=%b exp=1", b_ready);
    end
    step();
    b_valid = 1'b0;
    total++;
    if (rf_we !== 1'b0 || pending[0] !== 1'b0) begin
      bad++; $display("[TB] FAIL x0_write got=we%b/p0=%b exp=we0/p0=0", rf_we, pending[0]);
    end
    iss_valid = 1'b1; iss_rd = 5'd0;
    step();
    iss_valid = 1'b0;
    total++;
    if (pending !== 32'h0) begin
      bad++; $display("[TB] FAIL x0_issue got=%h exp=00000000", pending);
    end
  endtask

  task automatic test_scoreboard();
    iss_valid = 1'b1; iss_rd = 5'd7; q_rs1 = 5'd7;
    step();
    iss_valid = 1'b0;
    total++;
    if (rs1_busy !== 1'b1 || pending !== 32'h0000_0080) begin
      bad++; $display("[TB] FAIL sb_set got=%b/%h exp=1/00000080", rs1_busy, pending);
    end
    a_valid = 1'b1; a_rd = 5'd7; a_data = 32'h0000_0077;
    step();
    a_valid = 1'b0;
`ifdef RF_WB_FWD_EN
    total++;
    if (rs1_busy !== 1'b0 || rs1_fwd !== 1'b1 || fwd_data !== 32'h0000_0077) begin
      bad++; $display("[TB] FAIL sb_fwd got=busy%b/fwd%b/%h exp=busy0/fwd1/00000077", rs1_busy, rs1_fwd, fwd_data);
    end
`else
    total++;
    if (rs1_busy !== 1'b1 || rf_we !== 1'b1 || rf_rd_addr !== 5'd7) begin
      bad++; $display("[TB] FAIL sb_inflight got=busy%b/we%b/%0d exp=busy1/we1/7", rs1_busy, rf_we, rf_rd_addr);
    end
`endif
    step();
    total++;
    if (rs1_busy !== 1'b0 || pending !== 32'h0) begin
      bad++; $display("[TB] FAIL sb_clear got=%b/%h exp=0/00000000", rs1_busy, pending);
    end
  endtask

  task automatic test_set_wins();
    iss_valid = 1'b1; iss_rd = 5'd3;
    step();
    iss_valid = 1'b0;
    a_valid = 1'b1; a_rd = 5'd3; a_data = 32'h0000_0033;
    step();
    a_valid = 1'b0;
    iss_valid = 1'b1; iss_rd = 5'd3;
    step();
    iss_valid = 1'b0;
    total++;
    if (pending[3] !== 1'b1 || rf_we !== 1'b0) begin
      bad++; $display("[TB] FAIL set_wins got=p3=%b/we%b exp=p3=1/we0", pending[3], rf_we);
    end
  endtask

  task automatic test_reset_mid();
    logic [4:0] regs [6];
    regs = '{5'd1, 5'd2, 5'd8, 5'd9, 5'd10, 5'd11};
    for (int i = 0; i < 6; i++) begin
      iss_valid = 1'b1; iss_rd = regs[i];
      if (i == 5) begin
        a_valid = 1'b1; a_rd = 5'd20; a_data = 32'h0000_0020;
      end
      step();
    end
    iss_valid = 1'b0; a_valid = 1'b0;
    total++;
    if (pending !== 32'h0000_0F0E || rf_we !== 1'b1) begin
      bad++; $display("[TB] FAIL pre_reset got=%h/we%b exp=00000f0e/we1", pending, rf_we);
    end
    #1 rst = 1'b1;
    #1;
    total++;
    if (pending !== 32'h0 || rf_we !== 1'b0) begin
      bad++; $display("[TB] FAIL async_reset got=%h/we%b exp=00000000/we0", pending, rf_we);
    end
    #1 rst = 1'b0;
    a_valid = 1'b1; a_rd = 5'd4; a_data = 32'hAAAA_0004;
    b_valid = 1'b1; b_rd = 5'd6; b_data = 32'hBBBB_0006;
    #1;
    total++;
    if (a_ready !== 1'b1 || b_ready !== 1'b0) begin
      bad++; $display("[TB] FAIL post_reset_tie got=a%b/b%b exp=a1/b0", a_ready, b_ready);
    end
    step();
    a_valid = 1'b0; b_valid = 1'b0;
    total++;
    if (rf_we !== 1'b1 || rf_rd_addr !== 5'd4 || rf_wdata !== 32'hAAAA_0004) begin
      bad++; $display("[TB] FAIL post_reset_write got=%b/%0d/%h exp=1/4/aaaa0004", rf_we, rf_rd_addr, rf_wdata);
    end
  endtask

  // Run all scenarios in order; the contention test directly follows reset
  // so its first tie sees the reset arbitration history.
  initial begin
    total = 0;
    bad = 0;
    test_reset();
    test_contention();
    test_single_a();
    test_x0();
    test_scoreboard();
    test_set_wins();
    test_reset_mid();
    step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
